// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS-lite core: decodes opcode/funct and
// steps fetch/decode/execute/memory/writeback, driving all datapath strobes.
module mc_ctrl #(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic [1:0]          npc_sel,
   output logic                ir_write,
   output logic                reg_write,
   output logic                reg_dst,
   output logic                alu_src,
   output logic [1:0]          ext_op,
   output logic [2:0]          alu_op,
   output logic                mem_req,
   output logic                mem_write,
   output logic                mem_to_reg,
   output logic                illegal,
   output logic                retire,
   output logic [RETIRE_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_ADDR, S_MEM_RD,
      S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

   localparam logic [1:0] NPC_SEQ    = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] EXT_ZERO   = 2'b00;
   localparam logic [1:0] EXT_SIGN   = 2'b01;
   localparam logic [1:0] EXT_HIGH   = 2'b10;
   localparam logic [2:0] ALU_ADD    = 3'b000;
   localparam logic [2:0] ALU_SUB    = 3'b001;
   localparam logic [2:0] ALU_OR     = 3'b010;

   state_t              state_q, state_d;
   logic [RETIRE_W-1:0] retired_q;
   logic                retireRaw;

   logic isRType, isAddu, isSubu, isOri, isLui, isLw, isSw, isBeq, isJ, isLegal;

   assign isRType = (opcode == 6'b000000);
   assign isAddu  = isRType && (funct == 6'b100001);
   assign isSubu  = isRType && (funct == 6'b100011);
   assign isOri   = (opcode == 6'b001101);
   assign isLui   = (opcode == 6'b001111);
   assign isLw    = (opcode == 6'b100011);
   assign isSw    = (opcode == 6'b101011);
   assign isBeq   = (opcode == 6'b000100);
   assign isJ     = (opcode == 6'b000010);
   assign isLegal = isAddu | isSubu | isOri | isLui | isLw | isSw | isBeq | isJ;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (retireRaw)
            retired_q <= retired_q + RETIRE_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (!isLegal)          state_d = S_TRAP;
            else if (isJ)          state_d = S_JUMP;
            else if (isBeq)        state_d = S_BRANCH;
            else if (isLw || isSw) state_d = S_ADDR;
            else                   state_d = S_EXEC;
         end
         S_EXEC:   state_d = S_WB_ALU;
         S_WB_ALU: state_d = S_FETCH;
         S_ADDR:   state_d = isLw ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
         S_MEM_WR: state_d = mem_ready ? S_FETCH : S_MEM_WR;
         S_WB_MEM: state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_FETCH;
      endcase
   end

   // Strobes decode from state and the held instruction; reset masks everything,
   // so an instruction aborted by rst never issues a write in that cycle.
   always_comb begin
      pc_write   = 1'b0;
      npc_sel    = NPC_SEQ;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      ext_op     = EXT_ZERO;
      alu_op     = ALU_ADD;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      retireRaw  = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
         end
         S_EXEC, S_WB_ALU: begin
            if (isSubu)     alu_op = ALU_SUB;
            else if (isOri) alu_op = ALU_OR;
            alu_src = isOri | isLui;
            ext_op  = isLui ? EXT_HIGH : EXT_ZERO;
            if (state_q == S_WB_ALU) begin
               reg_write = 1'b1;
               reg_dst   = isRType;
               retireRaw = 1'b1;
            end
         end
         S_ADDR, S_MEM_RD, S_MEM_WR: begin
            alu_src = 1'b1;
            ext_op  = EXT_SIGN;
            if (state_q != S_ADDR) mem_req = 1'b1;
            if (state_q == S_MEM_WR) begin
               mem_write = 1'b1;
               retireRaw = mem_ready;
            end
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retireRaw  = 1'b1;
         end
         S_BRANCH: begin
            alu_op    = ALU_SUB;
            ext_op    = EXT_SIGN;
            npc_sel   = NPC_BRANCH;
            pc_write  = zero;
            retireRaw = 1'b1;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            npc_sel   = NPC_JUMP;
            retireRaw = 1'b1;
         end
         S_TRAP:  illegal = 1'b1;
         default: ;
      endcase
      if (rst) begin
         pc_write   = 1'b0;
         npc_sel    = NPC_SEQ;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         alu_src    = 1'b0;
         ext_op     = EXT_ZERO;
         alu_op     = ALU_ADD;
         mem_req    = 1'b0;
         mem_write  = 1'b0;
         mem_to_reg = 1'b0;
         illegal    = 1'b0;
      end
   end

   assign retire  = retireRaw & ~rst;
   assign retired = rst ? '0 : retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: a per-instruction cycle table model queues the
// expected strobes for every cycle and a negedge monitor compares them.
module tb_mc_ctrl;

   localparam int RW = 4;

   typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_BAD} kind_t;

   typedef struct packed {
      logic       pcWrite;
      logic [1:0] npcSel;
      logic       irWrite;
      logic       regWrite;
      logic       regDst;
      logic       aluSrc;
      logic [1:0] extOp;
      logic [2:0] aluOp;
      logic       memReq;
      logic       memWrite;
      logic       memToReg;
      logic       illegal;
      logic       retire;
   } outVec_t;

   typedef struct packed {
      outVec_t       v;
      logic [RW-1:0] retired;
   } expItem_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    opcode, funct;
   logic          zero, mem_ready;
   logic          pc_write, ir_write, reg_write, reg_dst, alu_src;
   logic          mem_req, mem_write, mem_to_reg, illegal, retire;
   logic [1:0]    npc_sel, ext_op;
   logic [2:0]    alu_op;
   logic [RW-1:0] retired;

   expItem_t expQ[$];
   string    nameQ[$];
   expItem_t monItem;
   string    monName;
   outVec_t  actual;
   int       testsRun = 0;
   int       testsFailed = 0;
   int       modelRetired = 0;

   mc_ctrl #(.RETIRE_W(RW)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .npc_sel(npc_sel),
      .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op), .mem_req(mem_req),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
      .retire(retire), .retired(retired)
   );

   always #5 clk = ~clk;

   assign actual = {pc_write, npc_sel, ir_write, reg_write, reg_dst, alu_src,
                    ext_op, alu_op, mem_req, mem_write, mem_to_reg, illegal, retire};

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic checkOutput(input expItem_t it, input string name);
      testsRun++;
      if (actual !== it.v) begin
         testsFailed++;
         $display("[TB] FAIL %s strobes: got %05h expected %05h at %0t", name, actual, it.v, $time);
      end
      testsRun++;
      if (retired !== it.retired) begin
         testsFailed++;
         $display("[TB] FAIL %s retired: got %0d expected %0d at %0t", name, retired, it.retired, $time);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monItem = expQ.pop_front();
         monName = nameQ.pop_front();
         checkOutput(monItem, monName);
      end
   end

   // One cycle: drive inputs, queue the expectation, advance the model counter.
   task automatic applyStimulus(input outVec_t e, input logic ready, input logic z, input string name);
      expItem_t it;
      mem_ready = ready;
      zero = z;
      it.v = e;
      it.retired = modelRetired[RW-1:0];
      expQ.push_back(it);
      nameQ.push_back(name);
      if (e.retire) modelRetired = (modelRetired + 1) % (1 << RW);
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input int n, input logic ready);
      rst = 1'b1;
      modelRetired = 0;
      for (int i = 0; i < n; i++) applyStimulus('0, ready, rbit(), "reset");
      rst = 1'b0;
   endtask

   task automatic encode(input kind_t k);
      logic [5:0] badOp [4];
      logic [5:0] badFn [4];
      int idx;
      badOp = '{6'b111111, 6'b000000, 6'b000000, 6'b001000};
      badFn = '{6'b100001, 6'b100000, 6'b100010, 6'b100001};
      funct = 6'($urandom);
      case (k)
         K_ADDU: begin opcode = 6'b000000; funct = 6'b100001; end
         K_SUBU: begin opcode = 6'b000000; funct = 6'b100011; end
         K_ORI:  opcode = 6'b001101;
         K_LUI:  opcode = 6'b001111;
         K_LW:   opcode = 6'b100011;
         K_SW:   opcode = 6'b101011;
         K_BEQ:  opcode = 6'b000100;
         K_J:    opcode = 6'b000010;
         default: begin
            idx = $urandom_range(0, 3);
            opcode = badOp[idx];
            funct = badFn[idx];
         end
      endcase
   endtask

   task automatic fetchDecode(input kind_t k);
      outVec_t e;
      e = '0;
      e.irWrite = 1'b1;
      e.pcWrite = 1'b1;
      applyStimulus(e, rbit(), rbit(), "fetch");
      encode(k);
      applyStimulus('0, rbit(), rbit(), "decode");
   endtask

   task automatic runInstr(input kind_t k, input int waits, input logic z);
      outVec_t e;
      fetchDecode(k);
      e = '0;
      case (k)
         K_ADDU, K_SUBU, K_ORI, K_LUI: begin
            e.aluOp  = (k == K_SUBU) ? 3'b001 : (k == K_ORI) ? 3'b010 : 3'b000;
            e.aluSrc = (k == K_ORI) || (k == K_LUI);
            e.extOp  = (k == K_LUI) ? 2'b10 : 2'b00;
            applyStimulus(e, rbit(), rbit(), "exec");
            e.regWrite = 1'b1;
            e.regDst   = (k == K_ADDU) || (k == K_SUBU);
            e.retire   = 1'b1;
            applyStimulus(e, rbit(), rbit(), "wb_alu");
         end
         K_LW, K_SW: begin
            e.aluSrc = 1'b1;
            e.extOp  = 2'b01;
            applyStimulus(e, rbit(), rbit(), "addr");
            e.memReq   = 1'b1;
            e.memWrite = (k == K_SW);
            for (int i = 0; i < waits; i++) applyStimulus(e, 1'b0, rbit(), "mem_wait");
            e.retire = (k == K_SW);
            applyStimulus(e, 1'b1, rbit(), "mem_done");
            if (k == K_LW) begin
               e = '0;
               e.regWrite = 1'b1;
               e.memToReg = 1'b1;
               e.retire   = 1'b1;
               applyStimulus(e, rbit(), rbit(), "wb_mem");
            end
         end
         K_BEQ: begin
            e.aluOp   = 3'b001;
            e.extOp   = 2'b01;
            e.npcSel  = 2'b01;
            e.pcWrite = z;
            e.retire  = 1'b1;
            applyStimulus(e, rbit(), z, "branch");
         end
         K_J: begin
            e.pcWrite = 1'b1;
            e.npcSel  = 2'b10;
            e.retire  = 1'b1;
            applyStimulus(e, rbit(), rbit(), "jump");
         end
         default: ;
      endcase
   endtask

   task automatic runTrap(input int n);
      outVec_t e;
      fetchDecode(K_BAD);
      e = '0;
      e.illegal = 1'b1;
      for (int i = 0; i < n; i++) applyStimulus(e, rbit(), rbit(), "trap");
   endtask

   initial begin
      outVec_t e;
      kind_t k;
      rst = 1'b1;
      opcode = '0;
      funct = '0;
      zero = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      doReset(3, 1'b1);

      runInstr(K_ADDU, 0, 1'b0);
      runInstr(K_ORI, 0, 1'b0);
      runInstr(K_LW, 3, 1'b0);
      runInstr(K_SW, 0, 1'b0);
      runInstr(K_BEQ, 0, 1'b1);
      runInstr(K_BEQ, 0, 1'b0);
      runInstr(K_J, 0, 1'b0);
      runInstr(K_LUI, 1, 1'b0);
      runInstr(K_SUBU, 0, 1'b0);

      // Reset in the middle of a pending store wait must suppress the write.
      fetchDecode(K_SW);
      e = '0;
      e.aluSrc = 1'b1;
      e.extOp  = 2'b01;
      applyStimulus(e, 1'b0, 1'b0, "abort_addr");
      e.memReq = 1'b1;
      e.memWrite = 1'b1;
      applyStimulus(e, 1'b0, 1'b0, "abort_wait");
      doReset(1, 1'b1);

      runInstr(K_ADDU, 0, 1'b0);
      runTrap(20);
      doReset(2, 1'b1);
      runInstr(K_J, 0, 1'b0);

      for (int n = 0; n < 150; n++) begin
         k = kind_t'($urandom_range(0, 8));
         if (k == K_BAD) begin
            runTrap($urandom_range(1, 4));
            doReset($urandom_range(1, 2), rbit());
         end else begin
            runInstr(k, $urandom_range(0, 3), rbit());
         end
      end

      @(negedge clk);
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS-lite core. It turns the single-cycle datapath (pc, grp register file, extend, alu, instruction register, data memory, MuxKey selects) into a multi-cycle machine. It decodes the opcode and funct held in the instruction register and steps a Moore FSM through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and it handshakes with a variable-latency data memory.

## Interface
Parameters:
- RETIRE_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU result == 0
- mem_ready  in  1  data memory completed the current access this cycle
- pc_write  out  1  PC load enable
- npc_sel  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target
- ir_write  out  1  instruction register load enable
- reg_write  out  1  register file write enable
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- alu_src  out  1  ALU SrcB select: 0 = RD2, 1 = extended immediate
- ext_op  out  2  extender mode: 00 = zero, 01 = sign, 10 = imm<<16
- alu_op  out  3  ALU operation: 000 = ADD, 001 = SUB, 010 = OR
- mem_req  out  1  data memory access request
- mem_write  out  1  data memory write, qualified by mem_req
- mem_to_reg  out  1  writeback select: 0 = ALU, 1 = memory
- illegal  out  1  sticky flag: unsupported instruction decoded
- retire  out  1  one-cycle pulse on the final cycle of each instruction
- retired  out  RETIRE_W  count of retired instructions

## Operation
- Supported instructions (opcode/funct):
  - addu: 000000/100001
  - subu: 000000/100011
  - ori: 001101
  - lui: 001111
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - j: 000010
- Any other opcode, or an R-type with any other funct, is illegal.
- Outputs are decoded from state plus opcode/funct; opcode/funct are stable from DECODE until the next FETCH. Any output not listed for a state is 0.

States:
- FETCH:
  - ir_write=1, pc_write=1, npc_sel=00.
  - Next: DECODE.
- DECODE:
  - No strobes.
  - Next: illegal -> TRAP; j -> JUMP; beq -> BRANCH; lw/sw -> ADDR; otherwise EXEC.
- EXEC:
  - addu: alu_op=ADD, alu_src=0.
  - subu: alu_op=SUB, alu_src=0.
  - ori: alu_op=OR, alu_src=1, ext_op=00.
  - lui: alu_op=ADD, alu_src=1, ext_op=10 (rs is $0 by encoding).
  - Next: WB_ALU.
- WB_ALU:
  - EXEC selects are held, reg_write=1, mem_to_reg=0.
  - reg_dst=1 for R-type, 0 otherwise.
  - Next: FETCH.
- ADDR:
  - alu_op=ADD, alu_src=1, ext_op=01.
  - Next: MEM_RD for lw, MEM_WR for sw.
- MEM_RD:
  - ADDR selects are held, mem_req=1, mem_write=0.
  - Stays in MEM_RD until mem_ready=1, then WB_MEM.
- MEM_WR:
  - ADDR selects are held, mem_req=1, mem_write=1.
  - Stays in MEM_WR until mem_ready=1, then FETCH.
- WB_MEM:
  - reg_write=1, mem_to_reg=1, reg_dst=0.
  - Next: FETCH.
- BRANCH:
  - alu_op=SUB, alu_src=0, ext_op=01, npc_sel=01.
  - pc_write=zero. This output is combinational on zero (Mealy).
  - Next: FETCH.
- JUMP:
  - pc_write=1, npc_sel=10.
  - Next: FETCH.
- TRAP:
  - illegal=1, all strobes 0.
  - Left only by rst.

Retire and counter:
- retire=1 in WB_ALU, WB_MEM, BRANCH and JUMP, and in MEM_WR on the mem_ready cycle.
- retired increments on each retire cycle and wraps modulo 2^RETIRE_W.
- TRAP never retires.

## Timing
- Reset:
  - On a clk edge with rst=1: state=FETCH, retired=0, illegal=0.
  - While rst=1, every output is forced to 0, including the FETCH strobes.
  - The first FETCH strobes appear in the first cycle after rst falls.
- Reset during any state, including a pending memory wait, aborts the instruction. No write strobe is issued that cycle.
- Cycles per instruction:
  - R-type, ori, lui: 4 (F D E W).
  - lw: 5 + (cycles waiting for mem_ready).
  - sw: 4 + waits.
  - beq, j: 3.
- Memory handshake:
  - mem_req stays high and all selects stay stable every cycle until mem_ready=1 is sampled.
  - mem_ready is ignored outside MEM_RD and MEM_WR.
  - mem_ready may already be high in the first MEM cycle (zero wait).
- pc_write and reg_write never assert in the same cycle. mem_write never asserts without mem_req.

## Test plan
- Reset and fetch: hold rst for 3 cycles with mem_ready=1 -> all outputs 0 and retired=0 during reset; cycle 1 after release: ir_write=1, pc_write=1, npc_sel=00.
- addu ($rd=$rs+$rt), then ori with imm 0x00F0 -> DECODE/EXEC/WB in order; WB cycles show reg_write=1 with reg_dst=1 then 0; ori EXEC shows ext_op=00, alu_op=010; retire pulses twice; retired=2.
- lw with mem_ready held low for 3 cycles in MEM_RD -> mem_req held 3 cycles plus the ready cycle, selects stable; lw takes 8 cycles; the WB_MEM cycle shows mem_to_reg=1.
- sw with zero-wait memory -> 4 cycles; mem_req=1 and mem_write=1 for exactly one cycle; retire coincides with it.
- beq with zero=1, then beq with zero=0 -> pc_write=1/npc_sel=01 in the first BRANCH cycle and pc_write=0 in the second; j gives pc_write=1 with npc_sel=10; each takes 3 cycles.
- Illegal opcode 111111 -> DECODE then TRAP; illegal=1 is held for 20 cycles with no strobes and retired unchanged. Assert rst -> illegal=0, and FETCH resumes the cycle after release.
